// File: rtl/eBike_pkg.sv
// Shared types for the eBike A2D conversion scheduler: channel indices,
// A2D channel codes, scheduler states and the SPI command builder.
package eBike_pkg;

  typedef enum logic [1:0] {
    BATT   = 2'd0,
    CURR   = 2'd1,
    BRAKE  = 2'd2,
    TORQUE = 2'd3
  } chan_e;

  localparam logic [2:0] CODE_BATT   = 3'd0;
  localparam logic [2:0] CODE_CURR   = 3'd1;
  localparam logic [2:0] CODE_BRAKE  = 3'd3;
  localparam logic [2:0] CODE_TORQUE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TX1  = 3'd1,
    S_GAP  = 3'd2,
    S_TX2  = 3'd3,
    S_UPD  = 3'd4
  } sched_state_e;

  // Both transactions of a conversion use the same command word.
  function automatic logic [15:0] chan_cmd(input logic [1:0] idx);
    logic [2:0] code;
    case (chan_e'(idx))
      BATT:    code = CODE_BATT;
      CURR:    code = CODE_CURR;
      BRAKE:   code = CODE_BRAKE;
      default: code = CODE_TORQUE;
    endcase
    return {2'b00, code, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_rr_pick.sv
// Rotate-priority pick: first enabled channel at or above ptr, wrapping mod 4.
module a2d_rr_pick (
  input  logic [1:0] ptr_i,
  input  logic [3:0] chan_en_i,
  output logic [1:0] idx_o,
  output logic       valid_o
);

  logic [7:0] en_dbl;
  logic [3:0] en_rot;
  logic [1:0] off;

  // en_rot[j] is the enable of channel (ptr + j) mod 4
  assign en_dbl = {chan_en_i, chan_en_i};
  assign en_rot = en_dbl[ptr_i +: 4];

  always_comb begin
    off     = 2'd0;
    valid_o = 1'b1;
    if (en_rot[0])      off = 2'd0;
    else if (en_rot[1]) off = 2'd1;
    else if (en_rot[2]) off = 2'd2;
    else if (en_rot[3]) off = 2'd3;
    else                valid_o = 1'b0;
  end

  assign idx_o = ptr_i + off;

endmodule

// File: rtl/a2d_conv_sched.sv
// Shares the A2D SPI master among battery, current, brake and torque channels:
// periodic two-transaction reads, round-robin over enabled channels, stall watchdog.
//
// state  | meaning
// IDLE   | timer running; waiting for timer wrap or sample_now
// TX1    | first SPI transaction in flight; response discarded
// GAP    | one-cycle spacer before relaunching the transaction
// TX2    | second SPI transaction in flight; response captured on done
// UPD    | write captured result to the selected channel, pulse cnv_cmplt
module a2d_conv_sched
  import eBike_pkg::*;
#(
  parameter int PERIOD_W = 14,
  parameter int TO_W     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  chan_en,
  input  logic        sample_now,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt,
  output logic        spi_err
);

  sched_state_e          state_q, state_d;
  logic [PERIOD_W-1:0]   timer_q, timer_d;
  logic [TO_W-1:0]       wd_q, wd_d, wd_inc;
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            sel_q, sel_d;
  logic                  wrt_q, wrt_d;
  logic [15:0]           cmd_q, cmd_d;
  logic [11:0]           data_q, data_d;
  logic [3:0][11:0]      res_q, res_d;
  logic                  cnv_q, cnv_d;
  logic                  err_q, err_d;

  logic                  trigger;
  logic [1:0]            pick_idx;
  logic                  pick_valid;
  logic                  unused_rd_hi;

  // Upper response bits carry no conversion data.
  assign unused_rd_hi = ^rd_data[15:12];

  a2d_rr_pick u_pick (
    .ptr_i     (ptr_q),
    .chan_en_i (chan_en),
    .idx_o     (pick_idx),
    .valid_o   (pick_valid)
  );

  assign trigger = (timer_q == '1) || sample_now;
  assign wd_inc  = wd_q + TO_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    wd_d    = wd_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    data_d  = data_q;
    res_d   = res_q;
    cnv_d   = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        timer_d = timer_q + PERIOD_W'(1);
        if (trigger) begin
          timer_d = '0;
          if (pick_valid) begin
            sel_d   = pick_idx;
            ptr_d   = pick_idx + 2'd1;
            cmd_d   = chan_cmd(pick_idx);
            wrt_d   = 1'b1;
            wd_d    = '0;
            state_d = S_TX1;
          end
        end
      end
      S_TX1, S_TX2: begin
        wd_d = wd_inc;
        // done wins over the watchdog when both land in the same cycle
        if (done) begin
          if (state_q == S_TX2) begin
            data_d  = rd_data[11:0];
            state_d = S_UPD;
          end else begin
            state_d = S_GAP;
          end
        end else if (wd_inc == '1) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        wrt_d   = 1'b1;
        wd_d    = '0;
        state_d = S_TX2;
      end
      S_UPD: begin
        res_d[sel_q] = data_q;
        cnv_d        = 1'b1;
        err_d        = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      wd_q    <= '0;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      wrt_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      data_q  <= 12'h000;
      res_q   <= '0;
      cnv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wd_q    <= wd_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      res_q   <= res_d;
      cnv_q   <= cnv_d;
      err_q   <= err_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign batt      = res_q[0];
  assign curr      = res_q[1];
  assign brake     = res_q[2];
  assign torque    = res_q[3];
  assign cnv_cmplt = cnv_q;
  assign spi_err   = err_q;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Directed bench for a2d_conv_sched: vector table for the rotation, hand sequences
// for disable/sample_now, watchdog, done-at-limit and reset mid-transaction.
module tb_a2d_conv_sched;

  localparam int PW     = 4;
  localparam int TW     = 6;
  localparam int WD_LIM = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  chan_en;
  logic        sample_now;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data = 16'h0000;
  logic [11:0] batt, curr, brake, torque;
  logic        cnv_cmplt, spi_err;

  logic        done_m = 1'b0;
  logic        done_x = 1'b0;
  assign done = done_m | done_x;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wrt_cnt = 0;
  int          cmplt_cnt = 0;
  int          spi_d = 32;
  bit          spi_hold = 1'b0;
  logic [15:0] spi_val = 16'h0ABC;
  logic [11:0] exp_res [4];

  typedef struct {
    logic [3:0]  en;
    logic [15:0] val;
    logic [15:0] cmd;
    int          idx;
  } vec_t;
  vec_t vt [12];

  int ref_c, t_w1, t_w2, t_c, t_e, t_d, w0, c0;

  a2d_conv_sched #(.PERIOD_W(PW), .TO_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chan_en    (chan_en),
    .sample_now (sample_now),
    .wrt        (wrt),
    .cmd        (cmd),
    .done       (done),
    .rd_data    (rd_data),
    .batt       (batt),
    .curr       (curr),
    .brake      (brake),
    .torque     (torque),
    .cnv_cmplt  (cnv_cmplt),
    .spi_err    (spi_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wrt === 1'b1) wrt_cnt <= wrt_cnt + 1;
    if (cnv_cmplt === 1'b1) cmplt_cnt <= cmplt_cnt + 1;
  end

  // SPI master model: done arrives spi_d cycles after the wrt cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wrt === 1'b1 && !spi_hold) begin
        repeat (spi_d) @(posedge clk);
        #1;
        done_m  = 1'b1;
        rd_data = spi_val;
        @(posedge clk);
        #1;
        done_m = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return wrt;
      1:       return cnv_cmplt;
      2:       return spi_err;
      default: return done;
    endcase
  endfunction

  task automatic wait_hi(input int which, input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (sig(which) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout signal %0d: got none expected high within %0d cycles", which, limit);
    end
  endtask

  task automatic chk_regs(input string name);
    chk({name, "_batt"},   batt,   exp_res[0]);
    chk({name, "_curr"},   curr,   exp_res[1]);
    chk({name, "_brake"},  brake,  exp_res[2]);
    chk({name, "_torque"}, torque, exp_res[3]);
  endtask

  task automatic pulse_sample();
    sample_now = 1'b1;
    @(negedge clk);
    sample_now = 1'b0;
  endtask

  initial begin
    vt[0]  = '{4'hF,    16'h0ABC, 16'h0000, 0};
    vt[1]  = '{4'hF,    16'hF123, 16'h0800, 1};
    vt[2]  = '{4'hF,    16'h7456, 16'h1800, 2};
    vt[3]  = '{4'hF,    16'h0FFF, 16'h2000, 3};
    vt[4]  = '{4'hF,    16'h1000, 16'h0000, 0};
    vt[5]  = '{4'hF,    16'hE001, 16'h0800, 1};
    vt[6]  = '{4'hF,    16'h0555, 16'h1800, 2};
    vt[7]  = '{4'hF,    16'hAAAA, 16'h2000, 3};
    vt[8]  = '{4'b1010, 16'h0321, 16'h0800, 1};
    vt[9]  = '{4'b1010, 16'h0CDE, 16'h2000, 3};
    vt[10] = '{4'b1010, 16'h0777, 16'h0800, 1};
    vt[11] = '{4'b1010, 16'h0011, 16'h2000, 3};
    for (int k = 0; k < 4; k++) exp_res[k] = 12'h000;

    rst_n      = 1'b0;
    chan_en    = 4'hF;
    sample_now = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wrt", wrt, 1'b0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmplt", cnv_cmplt, 1'b0);
    chk("rst_err", spi_err, 1'b0);
    chk_regs("rst");
    rst_n = 1'b1;
    ref_c = cyc;

    // Rotation over the vector table; each wrt comes 16 cycles into IDLE.
    for (int i = 0; i < 12; i++) begin
      chan_en = vt[i].en;
      spi_val = vt[i].val;
      wait_hi(0, 100, t_w1);
      chk("wrt_delay", t_w1 - ref_c, 16);
      chk("cmd_tx1", cmd, vt[i].cmd);
      wait_hi(0, 100, t_w2);
      chk("wrt2_gap", t_w2 - t_w1, spi_d + 2);
      chk("cmd_tx2", cmd, vt[i].cmd);
      wait_hi(1, 100, t_c);
      chk("cmplt_lat", t_c - t_w1, 2 * spi_d + 4);
      exp_res[vt[i].idx] = vt[i].val[11:0];
      chk_regs("rot");
      chk("rot_err", spi_err, 1'b0);
      @(negedge clk);
      chk("cmplt_width", cnv_cmplt, 1'b0);
      ref_c = t_c;
    end

    // All channels disabled: timer wraps but nothing starts.
    chan_en = 4'h0;
    w0 = wrt_cnt;
    repeat (200) @(negedge clk);
    chk("dis_no_wrt", wrt_cnt - w0, 0);
    chk("dis_wrt_now", wrt, 1'b0);

    // sample_now starts at ptr (batt); a second sample_now in TX1 is ignored.
    chan_en = 4'hF;
    spi_val = 16'h0BAD;
    w0 = wrt_cnt;
    pulse_sample();
    chk("smp_wrt", wrt, 1'b1);
    chk("smp_cmd", cmd, 16'h0000);
    t_w1 = cyc;
    repeat (2) @(negedge clk);
    pulse_sample();
    wait_hi(0, 100, t_w2);
    chk("smp_wrt2_gap", t_w2 - t_w1, spi_d + 2);
    wait_hi(1, 100, t_c);
    chan_en = 4'h0;
    exp_res[0] = 12'hBAD;
    chk_regs("smp");
    @(negedge clk);
    chk("smp_wrt_count", wrt_cnt - w0, 2);

    // Stray done in IDLE.
    w0 = wrt_cnt;
    c0 = cmplt_cnt;
    done_x = 1'b1;
    @(negedge clk);
    done_x = 1'b0;
    repeat (20) @(negedge clk);
    chk("stray_wrt", wrt_cnt - w0, 0);
    chk("stray_cmplt", cmplt_cnt - c0, 0);
    chk_regs("stray");

    // Watchdog: no done at all on curr.
    chan_en  = 4'hF;
    spi_hold = 1'b1;
    c0 = cmplt_cnt;
    pulse_sample();
    chk("wd_wrt", wrt, 1'b1);
    chk("wd_cmd", cmd, 16'h0800);
    t_w1 = cyc;
    wait_hi(2, 100, t_e);
    chk("wd_lat", t_e - t_w1, WD_LIM);
    chk_regs("wd");
    chk("wd_cmplt", cmplt_cnt - c0, 0);

    // Back in IDLE: next conversion uses the advanced ptr (brake) and clears spi_err.
    spi_hold = 1'b0;
    spi_val  = 16'h0246;
    pulse_sample();
    chk("rec_wrt", wrt, 1'b1);
    chk("rec_cmd", cmd, 16'h1800);
    wait_hi(0, 100, t_w2);
    chk("rec_err_held", spi_err, 1'b1);
    wait_hi(1, 100, t_c);
    chk("rec_err_clr", spi_err, 1'b0);
    exp_res[2] = 12'h246;
    chk_regs("rec");

    // done landing exactly in the watchdog limit cycle counts as success.
    @(negedge clk);
    spi_d   = WD_LIM - 1;
    spi_val = 16'h0FED;
    wait_hi(0, 100, t_w1);
    chk("lim_cmd", cmd, 16'h2000);
    wait_hi(1, 300, t_c);
    chk("lim_lat", t_c - t_w1, 2 * (WD_LIM - 1) + 4);
    chk("lim_err", spi_err, 1'b0);
    exp_res[3] = 12'hFED;
    chk_regs("lim");

    // Reset pulse during TX2, then the late done must change nothing.
    @(negedge clk);
    spi_d   = 32;
    spi_val = 16'h0999;
    wait_hi(0, 100, t_w1);
    chk("rtx_cmd", cmd, 16'h0000);
    wait_hi(0, 100, t_w2);
    repeat (3) @(negedge clk);
    rst_n   = 1'b0;
    chan_en = 4'h0;
    c0 = cmplt_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) exp_res[k] = 12'h000;
    wait_hi(3, 100, t_d);
    repeat (8) @(negedge clk);
    chk("rtx_wrt", wrt, 1'b0);
    chk("rtx_cmd0", cmd, 16'h0000);
    chk("rtx_err", spi_err, 1'b0);
    chk("rtx_cmplt", cmplt_cnt - c0, 0);
    chk_regs("rtx");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
